tapped_shift_line: RTL and testbench
====================================

// Module: tapped_shift_line
// PURPOSE
//  Parametrised multi-stage shift line for the PWM loop datapath: delays/filters duty samples.
//  Adds shift enable, direction, sync clear, fill tracking, eviction output and a registered tap read.
//  Optional running sum of all stages for the loop averaging filter.
//  Sits between the sample source and the PWM compare logic.
// PARAMETERS
//  WIDTH   8                        bits per stage
//  DEPTH   8                        number of stages, >=2
//  TAP_W   $clog2(DEPTH)            tap select width (derived, do not override)
//  SUM_W   WIDTH+$clog2(DEPTH)      running sum width (derived)
// PORTS
//  clk         in   1              rising-edge clock
//  rst         in   1              async reset, active-high
//  shift_en    in   1              shift one stage this cycle
//  dir         in   1              0: in at stage 0 toward DEPTH-1; 1: in at DEPTH-1 toward 0
//  clear       in   1              sync flush of all stages and fill count
//  data_in     in   WIDTH          sample shifted in
//  stages      out  WIDTH*DEPTH    all stages flat; stage i at [i*WIDTH +: WIDTH]
//  full        out  1              fill count == DEPTH
//  fill        out  TAP_W+1        valid stages, saturates at DEPTH
//  evict_valid out  1              1-cycle pulse: shift occurred while full
//  evict_data  out  WIDTH          value pushed out by that shift
//  tap_sel     in   TAP_W          stage index to read
//  tap_data    out  WIDTH          registered stage[tap_sel]
//  tap_err     out  1              registered: tap_sel >= DEPTH
//  sum_out     out  SUM_W          sum of all stages (SHIFT_SUM_EN)
// BEHAVIOUR
//  - Reset (async, rst=1): all stages 0, fill 0, full 0, evict_valid 0, evict_data 0,
//    tap_data 0, tap_err 0, sum_out 0. Outputs stay at reset values while rst is high.
//  - Priority per edge: clear > shift_en > hold.
//  - clear: stages 0, fill 0, sum 0, evict_valid 0; simultaneous shift_en ignored.
//  - Shift dir=0: stage[0]<=data_in, stage[i]<=stage[i-1]; outgoing = stage[DEPTH-1].
//  - Shift dir=1: stage[DEPTH-1]<=data_in, stage[i]<=stage[i+1]; outgoing = stage[0].
//  - fill increments on each shift, saturates at DEPTH; full = (fill==DEPTH), registered.
//  - evict_valid/evict_data: registered on the shifting edge when full was already 1
//    pre-edge; evict_data = outgoing value; evict_valid low otherwise (single-cycle pulse,
//    stays high across back-to-back shifts). evict_data holds last value when not pulsing.
//  - dir change mid-stream: no reorder of stored data, fill unchanged; next shift uses new dir.
//  - Tap read: 1-cycle latency; tap_data samples stage[tap_sel] pre-shift contents on the edge.
//    tap_sel >= DEPTH (non-power-of-2 DEPTH): tap_data 0, tap_err 1.
//  - All arithmetic unsigned; fill never wraps.
// CONFIGURATION
//  SHIFT_SUM_EN defined: sum_out registered running sum, updated on shift edge:
//    sum <= sum + data_in - outgoing (outgoing is 0 until first fill since stages reset/clear to 0);
//    no overflow possible at SUM_W; cleared by rst and clear. Matches sum of stages every cycle.
//  SHIFT_SUM_EN undefined: sum_out tied to 0, no adder/subtractor logic.
// TESTING
//  Reset mid-stream: shift 3 values, assert rst -> stages all 0, fill 0, full 0 same cycle.
//  dir=0, shift 0x11..0x88 (8 shifts) -> stage0=0x88, stage7=0x11, full=1, no evict pulse;
//    9th shift 0x99 -> evict_valid=1, evict_data=0x11.
//  dir=1 after fill, shift 0xAA -> stage7=0xAA, evict_data=old stage0 (0x88), fill stays 8.
//  clear and shift_en same cycle with data_in=0x55 -> all stages 0, fill 0, evict_valid 0.
//  tap_sel=3 after fill in test 2 -> next cycle tap_data=0x55? no: =stage3=0x55 only if loaded;
//    use loaded pattern: tap_data=0x55 for stage3 value 0x55; DEPTH=6, tap_sel=7 -> tap_err=1, tap_data=0.
//  SHIFT_SUM_EN: shift 8x 0xFF -> sum_out=0x7F8; shift 0x00 -> sum_out=0x6F9; clear -> 0.

Source files
------------

// File: rtl/tapped_shift_line.sv
// Bidirectional tapped shift line with fill tracking, eviction output and registered tap read.
// Define SHIFT_SUM_EN to enable the registered running sum of all stages on sum_out.
module tapped_shift_line #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int TAP_W = $clog2(DEPTH),
  localparam int SUM_W = WIDTH + $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   shift_en,
  input  logic                   dir,
  input  logic                   clear,
  input  logic [WIDTH-1:0]       data_in,
  output logic [WIDTH*DEPTH-1:0] stages,
  output logic                   full,
  output logic [TAP_W:0]         fill,
  output logic                   evict_valid,
  output logic [WIDTH-1:0]       evict_data,
  input  logic [TAP_W-1:0]       tap_sel,
  output logic [WIDTH-1:0]       tap_data,
  output logic                   tap_err,
  output logic [SUM_W-1:0]       sum_out
);

  localparam logic [TAP_W:0] FILL_MAX = (TAP_W+1)'(DEPTH);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];
  logic [TAP_W:0]   fill_q, fill_d;
  logic             full_q, full_d;
  logic             evict_valid_q, evict_valid_d;
  logic [WIDTH-1:0] evict_data_q, evict_data_d;
  logic [WIDTH-1:0] tap_data_q, tap_data_d;
  logic             tap_err_q, tap_err_d;
  logic [WIDTH-1:0] outgoing;
  logic             do_shift;

  assign do_shift = shift_en && !clear;
  assign outgoing = dir ? stage_q[0] : stage_q[DEPTH-1];

  // Each stage picks its neighbour on the upstream side of the current direction.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    logic [WIDTH-1:0] from_lo;
    logic [WIDTH-1:0] from_hi;
    if (gi == 0) begin : g_lo_in
      assign from_lo = data_in;
    end else begin : g_lo_prev
      assign from_lo = stage_q[gi-1];
    end
    if (gi == DEPTH-1) begin : g_hi_in
      assign from_hi = data_in;
    end else begin : g_hi_next
      assign from_hi = stage_q[gi+1];
    end
    assign stage_d[gi] = clear    ? '0 :
                         shift_en ? (dir ? from_hi : from_lo) :
                                    stage_q[gi];
    assign stages[gi*WIDTH +: WIDTH] = stage_q[gi];
  end

  always_comb begin
    fill_d        = fill_q;
    evict_valid_d = 1'b0;
    evict_data_d  = evict_data_q;
    if (clear) begin
      fill_d = '0;
    end else if (shift_en) begin
      if (fill_q != FILL_MAX) fill_d = fill_q + 1'b1;
      evict_valid_d = full_q;
      if (full_q) evict_data_d = outgoing;
    end
    full_d = (fill_d == FILL_MAX);
  end

  // Out-of-range selects only exist when DEPTH is not a power of two.
  always_comb begin
    tap_err_d  = ({1'b0, tap_sel} >= FILL_MAX);
    tap_data_d = tap_err_d ? '0 : stage_q[tap_sel];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
      fill_q        <= '0;
      full_q        <= 1'b0;
      evict_valid_q <= 1'b0;
      evict_data_q  <= '0;
      tap_data_q    <= '0;
      tap_err_q     <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= stage_d[i];
      fill_q        <= fill_d;
      full_q        <= full_d;
      evict_valid_q <= evict_valid_d;
      evict_data_q  <= evict_data_d;
      tap_data_q    <= tap_data_d;
      tap_err_q     <= tap_err_d;
    end
  end

  assign fill        = fill_q;
  assign full        = full_q;
  assign evict_valid = evict_valid_q;
  assign evict_data  = evict_data_q;
  assign tap_data    = tap_data_q;
  assign tap_err     = tap_err_q;

`ifdef SHIFT_SUM_EN
  logic [SUM_W-1:0] sum_q, sum_d;

  // Stages start at zero, so subtracting the outgoing value keeps the sum exact.
  always_comb begin
    sum_d = sum_q;
    if (clear) sum_d = '0;
    else if (do_shift) sum_d = sum_q + SUM_W'(data_in) - SUM_W'(outgoing);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sum_q <= '0;
    else     sum_q <= sum_d;
  end

  assign sum_out = sum_q;
`else
  logic unused_shift;
  assign unused_shift = do_shift;
  assign sum_out      = '0;
`endif

endmodule

// File: tb/tb_tapped_shift_line.sv
// Scoreboard bench for tapped_shift_line: a DEPTH=8 instance against a reference model,
// plus a DEPTH=6 instance for the out-of-range tap select.
module tb_tapped_shift_line;

`ifdef SHIFT_SUM_EN
  localparam bit SUM_ON = 1'b1;
`else
  localparam bit SUM_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        shift_en = 1'b0;
  logic        dir = 1'b0;
  logic        clear = 1'b0;
  logic [7:0]  data_in = '0;
  logic [2:0]  tap_sel = '0;
  logic [2:0]  tap_sel6 = '0;

  logic [63:0] stages;
  logic        full, evict_valid, tap_err;
  logic [3:0]  fill;
  logic [7:0]  evict_data, tap_data;
  logic [10:0] sum_out;

  logic [47:0] stages6;
  logic        full6, evict_valid6, tap_err6;
  logic [3:0]  fill6;
  logic [7:0]  evict_data6, tap_data6;
  logic [10:0] sum_out6;

  int checks = 0;
  int failures = 0;
  int txn = 0;

  always #5 clk = ~clk;

  tapped_shift_line #(.WIDTH(8), .DEPTH(8)) u_dut (
    .clk(clk), .rst(rst), .shift_en(shift_en), .dir(dir), .clear(clear),
    .data_in(data_in), .stages(stages), .full(full), .fill(fill),
    .evict_valid(evict_valid), .evict_data(evict_data), .tap_sel(tap_sel),
    .tap_data(tap_data), .tap_err(tap_err), .sum_out(sum_out)
  );

  tapped_shift_line #(.WIDTH(8), .DEPTH(6)) u_dut6 (
    .clk(clk), .rst(rst), .shift_en(shift_en), .dir(dir), .clear(clear),
    .data_in(data_in), .stages(stages6), .full(full6), .fill(fill6),
    .evict_valid(evict_valid6), .evict_data(evict_data6), .tap_sel(tap_sel6),
    .tap_data(tap_data6), .tap_err(tap_err6), .sum_out(sum_out6)
  );

  typedef struct {
    logic [63:0] st;
    logic [3:0]  fill;
    logic        full;
    logic        ev;
    logic [7:0]  evd;
    logic [7:0]  tap;
    logic        terr;
    logic [10:0] sum;
  } exp_t;

  exp_t sb[$];

  // Reference model state (DEPTH=8)
  logic [7:0] m_st [8];
  int         m_fill;
  logic       m_full, m_ev;
  logic [7:0] m_evd;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_st[i] = '0;
    m_fill = 0;
    m_full = 1'b0;
    m_ev   = 1'b0;
    m_evd  = '0;
  endtask

  function automatic logic [10:0] model_sum();
    int s = 0;
    for (int i = 0; i < 8; i++) s += m_st[i];
    return SUM_ON ? 11'(s) : 11'd0;
  endfunction

  // Drive one cycle, push the model's expectation, then compare after the edge.
  task automatic step(input logic sh, input logic dr, input logic cl,
                      input logic [7:0] di, input logic [2:0] ts);
    exp_t e, g;
    logic [7:0] outv;
    shift_en = sh; dir = dr; clear = cl; data_in = di; tap_sel = ts;
    e.tap  = m_st[ts];
    e.terr = 1'b0;
    if (cl) begin
      for (int i = 0; i < 8; i++) m_st[i] = '0;
      m_fill = 0;
      m_ev   = 1'b0;
    end else if (sh) begin
      outv = dr ? m_st[0] : m_st[7];
      m_ev = m_full;
      if (m_full) m_evd = outv;
      if (dr) begin
        for (int i = 0; i < 7; i++) m_st[i] = m_st[i+1];
        m_st[7] = di;
      end else begin
        for (int i = 7; i > 0; i--) m_st[i] = m_st[i-1];
        m_st[0] = di;
      end
      if (m_fill < 8) m_fill++;
    end else begin
      m_ev = 1'b0;
    end
    m_full = (m_fill == 8);
    for (int i = 0; i < 8; i++) e.st[i*8 +: 8] = m_st[i];
    e.fill = 4'(m_fill);
    e.full = m_full;
    e.ev   = m_ev;
    e.evd  = m_evd;
    e.sum  = model_sum();
    sb.push_back(e);
    @(posedge clk);
    #1;
    g = sb.pop_front();
    txn++;
    $display("txn %0d sh=%0b dir=%0b clr=%0b din=%02h fill=%0d ev=%0b evd=%02h tap=%02h sum=%0h",
             txn, sh, dr, cl, di, fill, evict_valid, evict_data, tap_data, sum_out);
    check_val("stages", stages, g.st);
    check_val("fill", fill, g.fill);
    check_val("full", full, g.full);
    check_val("evict_valid", evict_valid, g.ev);
    check_val("evict_data", evict_data, g.evd);
    check_val("tap_data", tap_data, g.tap);
    check_val("tap_err", tap_err, g.terr);
    check_val("sum_out", sum_out, g.sum);
  endtask

  task automatic fill_ramp();
    for (int k = 1; k <= 8; k++) step(1'b1, 1'b0, 1'b0, 8'(k * 17), 3'd3);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_stages", stages, 64'd0);
    check_val("rst_fill", fill, 4'd0);
    check_val("rst_full", full, 1'b0);
    check_val("rst_evict_valid", evict_valid, 1'b0);
    check_val("rst_evict_data", evict_data, 8'd0);
    check_val("rst_tap_data", tap_data, 8'd0);
    check_val("rst_tap_err", tap_err, 1'b0);
    check_val("rst_sum", sum_out, 11'd0);
    check_val("rst_fill6", fill6, 4'd0);
    rst = 1'b0;

    // Reset mid-stream takes effect without waiting for an edge
    step(1'b1, 1'b0, 1'b0, 8'h01, 3'd0);
    step(1'b1, 1'b0, 1'b0, 8'h02, 3'd0);
    step(1'b1, 1'b0, 1'b0, 8'h03, 3'd0);
    shift_en = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("midrst_stages", stages, 64'd0);
    check_val("midrst_fill", fill, 4'd0);
    check_val("midrst_full", full, 1'b0);
    @(posedge clk);
    #1;
    check_val("rsthold_stages", stages, 64'd0);
    check_val("rsthold_fill", fill, 4'd0);
    rst = 1'b0;
    model_reset();

    // Fill with 0x11..0x88 in dir=0
    fill_ramp();
    check_val("fill_stage0", stages[7:0], 8'h88);
    check_val("fill_stage7", stages[63:56], 8'h11);
    check_val("fill_full", full, 1'b1);
    check_val("fill_no_evict", evict_valid, 1'b0);
    tap_sel6 = 3'd3;
    step(1'b0, 1'b0, 1'b0, 8'h00, 3'd3);
    check_val("tap3", tap_data, 8'h55);
    check_val("tap3_d6", tap_data6, 8'h55);
    check_val("tap3_err_d6", tap_err6, 1'b0);
    step(1'b1, 1'b0, 1'b0, 8'h99, 3'd3);
    check_val("evict9_valid", evict_valid, 1'b1);
    check_val("evict9_data", evict_data, 8'h11);
    tap_sel6 = 3'd7;
    step(1'b0, 1'b0, 1'b0, 8'h00, 3'd0);
    check_val("tap7_err_d6", tap_err6, 1'b1);
    check_val("tap7_data_d6", tap_data6, 8'h00);
    check_val("evict_drop", evict_valid, 1'b0);

    // Refill, then shift once with dir=1
    step(1'b0, 1'b0, 1'b1, 8'h00, 3'd0);
    fill_ramp();
    step(1'b1, 1'b1, 1'b0, 8'hAA, 3'd0);
    check_val("dir1_stage7", stages[63:56], 8'hAA);
    check_val("dir1_evict_data", evict_data, 8'h88);
    check_val("dir1_fill", fill, 4'd8);

    // clear beats a simultaneous shift
    step(1'b1, 1'b1, 1'b1, 8'h55, 3'd0);
    check_val("clr_stages", stages, 64'd0);
    check_val("clr_fill", fill, 4'd0);
    check_val("clr_evict_valid", evict_valid, 1'b0);

    // Running sum sequence
    for (int k = 0; k < 8; k++) step(1'b1, 1'b0, 1'b0, 8'hFF, 3'd0);
    check_val("sum_full_ff", sum_out, SUM_ON ? 11'h7F8 : 11'h000);
    step(1'b1, 1'b0, 1'b0, 8'h00, 3'd0);
    check_val("sum_after_zero", sum_out, SUM_ON ? 11'h6F9 : 11'h000);
    step(1'b0, 1'b0, 1'b1, 8'h00, 3'd0);
    check_val("sum_clear", sum_out, 11'h000);

    // Random traffic including mid-stream direction changes
    tap_sel6 = 3'd0;
    for (int n = 0; n < 60; n++) begin
      step(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 19) == 0), 8'($urandom_range(0, 255)),
           3'($urandom_range(0, 7)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
